serial_array_loader: RTL and testbench

SERIAL_ARRAY_LOADER -- requirements
Module: serial_array_loader

---
 rtl/serial_array_loader_pkg.sv | 17 +
 rtl/serial_array_loader_regfile.sv | 46 ++++
 rtl/serial_array_loader.sv | 157 +++++++++++++++
 tb/tb_serial_array_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_array_loader_pkg.sv
// serial_array_loader_pkg
//   Shared definitions for the serial array loader and the downstream
//   array-scan stage: array geometry and the loader FSM state encoding.
package serial_array_loader_pkg;

    localparam int N_WORDS = 9;    // words stored before the load is complete
    localparam int WORD_W  = 32;   // data bits per word
    localparam int ADDR_W  = 4;    // width of word addresses and the word count

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/serial_array_loader_regfile.sv
// loader_regfile
//   N_WORDS x WORD_W word storage for the serial array loader.
//   One synchronous write port, one combinational read port, synchronous
//   active-high reset that zeroes every location.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address; addresses >= N_WORDS read as zero
//   rd_data  : read data (combinational)
module loader_regfile
    import serial_array_loader_pkg::*;
#(
    parameter int N_WORDS = serial_array_loader_pkg::N_WORDS,
    parameter int WORD_W  = serial_array_loader_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam logic [3:0] LAST_ADDR = 4'(N_WORDS - 1);

    logic [WORD_W-1:0] mem [N_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_addr <= LAST_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range reads return zero so the scan stage can sweep the full
    // address space safely.
    assign rd_data = (rd_addr <= LAST_ADDR) ? mem[rd_addr] : '0;

endmodule

// File: rtl/serial_array_loader.sv
// serial_array_loader
//   Receives framed serial words (start bit 1, WORD_W data bits LSB-first,
//   even parity bit; one bit per clk) and stores good words into
//   consecutive array locations until N_WORDS have been loaded.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a start bit (din == 1)
//   DATA   | shifting in data bits, bitcnt selects the bit position
//   PARITY | sampling the parity bit; write on pass, flag on fail
//   DONE   | N_WORDS stored; din ignored until clear
//
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset (wins over clear)
//   din          : serial input, idles low
//   clear        : single-cycle re-arm/abort; memory is retained
//   rd_addr      : read index from the array-scan stage
//   rd_data      : word at rd_addr (two's complement), zero if out of range
//   words_loaded : number of words accepted since reset/clear
//   load_done    : high while all N_WORDS words are loaded
//   parity_err   : sticky, set when a frame fails parity
module serial_array_loader
    import serial_array_loader_pkg::*;
#(
    parameter int N_WORDS = serial_array_loader_pkg::N_WORDS,
    parameter int WORD_W  = serial_array_loader_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              clear,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [3:0]        words_loaded,
    output logic              load_done,
    output logic              parity_err
);

    localparam int               CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [3:0]       LAST_IDX = 4'(N_WORDS - 1);

    loader_state_t     state;
    loader_state_t     next_state;
    logic [CNT_W-1:0]  bitcnt;
    logic [WORD_W-1:0] shift_reg;
    logic              par_acc;
    logic              par_ok;
    logic              wr_en;

    // Even parity: data bits XOR parity bit must be zero.
    assign par_ok = ~(par_acc ^ din);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (din) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bitcnt == LAST_BIT) begin
                    next_state = PARITY;
                end
            end
            PARITY: begin
                next_state = IDLE;
                if (par_ok) begin
                    wr_en = 1'b1;
                    if (words_loaded == LAST_IDX) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // clear aborts everything, including a write on a good parity sample.
        if (clear) begin
            next_state = IDLE;
            wr_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt       <= '0;
            shift_reg    <= '0;
            par_acc      <= 1'b0;
            words_loaded <= '0;
            parity_err   <= 1'b0;
        end else if (clear) begin
            bitcnt       <= '0;
            shift_reg    <= '0;
            par_acc      <= 1'b0;
            words_loaded <= '0;
            parity_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din) begin
                        bitcnt    <= '0;
                        shift_reg <= '0;
                        par_acc   <= 1'b0;
                    end
                end
                DATA: begin
                    shift_reg[bitcnt] <= din;
                    par_acc           <= par_acc ^ din;
                    if (bitcnt != LAST_BIT) begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (par_ok) begin
                        words_loaded <= words_loaded + 4'd1;
                    end else begin
                        parity_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign load_done = (state == DONE);

    loader_regfile #(
        .N_WORDS (N_WORDS),
        .WORD_W  (WORD_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en),
        .wr_addr (words_loaded),
        .wr_data (shift_reg),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_serial_array_loader.sv
// tb_serial_array_loader
//   Self-checking bench for serial_array_loader. A bench-side model of the
//   array, word count and flags is updated as each frame is driven; words
//   expected to be written are queued and popped once the frame completes.
module tb_serial_array_loader;
    import serial_array_loader_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              din;
    logic              clear;
    logic [3:0]        rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [3:0]        words_loaded;
    logic              load_done;
    logic              parity_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_start_cyc = 0;
    int   rise_cyc = -1;
    logic prev_ld = 1'b0;

    logic [31:0] model_mem [16];
    int          model_wl;
    logic        model_done;
    logic        model_perr;
    exp_t        exp_q [$];

    logic [31:0] load_words [9] = '{32'd100, 32'd1, 32'd2, 32'd5, 32'd7,
                                    32'd8, 32'd1121, 32'd2021, 32'd2048};

    always #5 clk = ~clk;

    serial_array_loader #(
        .N_WORDS (N_WORDS),
        .WORD_W  (WORD_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .clear        (clear),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .parity_err   (parity_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load_done && !prev_ld) rise_cyc = cyc;
        prev_ld = load_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        model_wl   = 0;
        model_done = 1'b0;
        model_perr = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        exp_q.delete();
    endtask

    // Drives one full frame; optionally flips the parity bit and/or pulses
    // clear during the parity cycle.
    task automatic send_frame(input logic [31:0] w, input bit flip, input bit clr_par);
        din = 1'b1;
        tick();
        last_start_cyc = cyc;
        for (int i = 0; i < 32; i++) begin
            din = w[i];
            tick();
        end
        din   = (^w) ^ flip;
        clear = clr_par;
        tick();
        din   = 1'b0;
        clear = 1'b0;
        if (clr_par) begin
            model_clear();
        end else if (!model_done) begin
            if (flip) begin
                model_perr = 1'b1;
            end else begin
                model_mem[model_wl] = w;
                exp_q.push_back('{4'(model_wl), w});
                model_wl++;
                if (model_wl == N_WORDS) model_done = 1'b1;
            end
        end
    endtask

    task automatic check_frame();
        exp_t e;
        check("words_loaded", 32'(words_loaded), 32'(model_wl));
        check("load_done", 32'(load_done), 32'(model_done));
        check("parity_err", 32'(parity_err), 32'(model_perr));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            #1;
            check("written_word", rd_data, e.data);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            check(tag, rd_data, model_mem[a]);
        end
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        reset   = 1'b1;
        din     = 1'b0;
        clear   = 1'b0;
        rd_addr = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_frame();
        sweep("reset_mem");

        // Nine good frames with idle gaps.
        for (int k = 0; k < 9; k++) begin
            send_frame(load_words[k], 1'b0, 1'b0);
            check_frame();
            idle(2);
        end
        sweep("load_mem");

        // Frames while DONE are ignored.
        send_frame(32'hDEADBEEF, 1'b0, 1'b0);
        send_frame(32'h12345678, 1'b0, 1'b0);
        idle(1);
        check_frame();
        rd_addr = 4'd12;
        #1;
        check("rd_addr_12", rd_data, 32'd0);
        sweep("done_mem");

        // clear re-arms, memory retained.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        check_frame();
        sweep("clear_mem");

        // Bad parity on the third frame.
        send_frame(32'h11, 1'b0, 1'b0); check_frame(); idle(1);
        send_frame(32'h22, 1'b0, 1'b0); check_frame(); idle(1);
        send_frame(32'h33, 1'b1, 1'b0); check_frame(); idle(1);
        send_frame(32'h44, 1'b0, 1'b0); check_frame(); idle(1);

        // clear at data bit 10 of the fourth frame.
        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        send_frame(32'hA5A5_0001, 1'b0, 1'b0); check_frame(); idle(1);
        send_frame(32'h8000_0002, 1'b0, 1'b0); check_frame(); idle(1);
        send_frame(32'h0F0F_0003, 1'b0, 1'b0); check_frame(); idle(1);
        din = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            din = i[0];
            tick();
        end
        din   = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        idle(3);
        check_frame();
        sweep("abort_mem");
        send_frame(32'hCAFE_0001, 1'b0, 1'b0);
        check_frame();
        idle(1);

        // clear coincident with a good parity sample.
        send_frame(32'h0BAD_0BAD, 1'b0, 1'b1);
        idle(1);
        check_frame();
        sweep("clr_parity_mem");

        // Nine back-to-back frames.
        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        for (int k = 0; k < 9; k++) begin
            if (k == 8) rise_cyc = -1;
            send_frame($urandom, 1'b0, 1'b0);
            check_frame();
        end
        idle(1);
        check("ld_latency", 32'(rise_cyc - last_start_cyc), 32'd33);
        sweep("b2b_mem");

        // Reset mid-frame.
        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        din = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        din   = 1'b0;
        model_reset();
        tick();
        check_frame();
        sweep("reset_mid_mem");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
